uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
Parametrised baud/timing generator for the UART, the successor to the fixed 16x, 8-bit-divisor generator. It has independent receive and transmit timing chains, each built as prescaler → oversample counter → bit strobe. New over the previous generation:
- configurable oversample ratio and divisor width
- fractional divisor
- programmable receive timeout length
- false-start detection
Sits between the register file (divisor/timeout fields) and the rx/tx codec FSMs.

Parameters:
OSR, 16, oversample sub-ticks per bit; even, 4..64
DIV_W, 16, integer divisor width (DLL/DLM)
FRAC_W, 4, fractional divisor width; 0 disables fractional logic
TO_W, 8, timeout length width, in bit times

Ports:
clk_i  in  1  clock
nrst_i  in  1  reset, asynchronous, active-low
en_i  in  1  global enable; low = both chains held cleared
div_i  in  DIV_W  integer divisor, clocks per sub-tick; 0 = halted
frac_i  in  FRAC_W  fractional divisor, frac_i/2^FRAC_W clocks added per sub-tick
timeout_bits_i  in  TO_W  receive timeout in bit times; 0 = disabled
rxd_i  in  1  synchronised, deglitched receive data
rx_hunt_i  in  1  rx FSM accepts a start edge (idle/stop/timeout-wait)
rx_run_i  in  1  rx FSM not idle; low clears rx chain
tx_run_i  in  1  tx FSM not idle; low clears tx chain
rx_start_o  out  1  start-edge pulse
rx_sample_o  out  1  mid-bit sample pulse
rx_bit_o  out  1  rx bit-period end pulse
rx_false_start_o  out  1  start bit high at its mid-sample
rx_timeout_o  out  1  timeout pulse
tx_bit_o  out  1  tx bit-period end pulse

Behaviour:
- **Reset:** all outputs 0; all counters, accumulators and carry flags 0; rxd_l (registered rxd_i) 1.
- **Halt condition:** a chain is "active" only when en_i=1, div_i≠0 and its run input is 1.
  - Inactive chain: prescaler, sub_cnt, frac acc and carry clear next cycle.
  - Inactive chain: no pulses.
- **Prescaler:**
  - Per active cycle pre increments.
  - Sub-tick (combinational) when pre >= P-1, where P = div_i + carry.
  - On a sub-tick: pre clears, and {carry, acc} <= acc + frac_i.
  - The >= compare makes a divisor decrease mid-bit take effect without wrap-around.
- **Oversample counter:** sub_cnt counts sub-ticks 0..OSR-1.
  - Sample strobe = sub-tick while sub_cnt == OSR/2-1.
  - Bit strobe = sub-tick while sub_cnt == OSR-1; sub_cnt then wraps to 0.
- **Timing, div_i=d, frac_i=0:**
  - Taking the first active cycle as cycle 1, the bit strobe lands on cycle OSR·d.
  - The sample strobe lands on cycle (OSR/2)·d.
  - Steady state: one strobe per OSR·d clocks.
  - d=1 gives a sub-tick every cycle.
- **Fractional:** average sub-tick period is d + frac_i/2^FRAC_W clocks; the carry stretches the following sub-tick by one clock.
- **rx_start_o (combinational):**
  - Asserted when rxd_l=1, rxd_i=0, rx_hunt_i=1, en_i=1 and div_i≠0.
  - Same cycle it clears pre, sub_cnt, acc, carry and the timeout counter, overriding any increment.
  - The cycle after the edge counts as cycle 1 for the timing above.
- **False start:**
  - A flag sets on rx_start_o and clears on the next rx_sample_o.
  - rx_false_start_o = rx_sample_o & flag & rxd_i. rx_sample_o is still issued.
- **Timeout counter (TO_W bits):**
  - Increments on each rx_bit_o while rx_run_i=1.
  - rx_timeout_o = rx_bit_o & (to_cnt == timeout_bits_i-1) & (timeout_bits_i≠0). The counter clears on that pulse.
  - Also clears on rx_start_o or when the chain is inactive.
  - Saturates rather than wraps if timeout_bits_i is lowered below the current count.
- **Tx chain:** identical prescaler/sub_cnt/frac structure driven by tx_run_i. tx_bit_o = its bit strobe. No edge resync.
- **Simultaneous events:** rx_start_o on the same cycle as an rx sub-tick wins; no rx_sample_o/rx_bit_o is issued that cycle.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronous); no pulse is issued in the reset cycle.

Decomposition:
- Package uart_package holds:
  - OSR/DIV_W/FRAC_W/TO_W defaults
  - a baud_cfg_t struct (div, frac, timeout_bits)
  - a baud_strobe_t struct grouping the rx output pulses
- One sub-module: uart_baud_chain (prescaler + fractional accumulator + oversample counter, with run/clear inputs; outputs sub_tick, sample, bit). Instantiate it twice; rx edge/false-start/timeout logic sits in the top.

Test Plan:
- OSR=16, div=1, frac=0, tx_run_i held high → tx_bit_o on cycles 16, 32, 48; drop tx_run_i at cycle 40 → no pulse at 48, counters 0.
- div=3: falling rxd_i with rx_hunt_i=1 → rx_start_o in the edge cycle; rx_sample_o at cycle 24; rx_bit_o at cycle 48, then every 48 cycles.
- div=4, frac=8 (FRAC_W=4) → sub-ticks alternate 4/5 clocks; tx_bit_o spacing exactly 72 clocks.
- rxd_i low for 2 cycles only, div=2 → rx_start_o; then rx_sample_o with rx_false_start_o=1 at cycle 16.
- timeout_bits_i=40, rx_run_i high, no edges → rx_timeout_o coincides with the 40th rx_bit_o, then repeats every 40 bits. A new start edge at bit 30 restarts the count.
- div_i=0 or en_i=0 → no output pulses ever; assert nrst_i mid-bit → all outputs 0 and the next bit is timed from scratch.

Source files
------------

// File: rtl/uart_baud_gen_pkg.sv
// Shared definitions for the UART baud/timing generator.
// Holds the parameter defaults, the configuration record supplied by the
// register file, and the grouping of the receive-side strobes.
package uart_baud_gen_pkg;

   localparam int OSR_DEF    = 16;
   localparam int DIV_W_DEF  = 16;
   localparam int FRAC_W_DEF = 4;
   localparam int TO_W_DEF   = 8;

   typedef struct packed {
      logic [DIV_W_DEF-1:0]  div;
      logic [FRAC_W_DEF-1:0] frac;
      logic [TO_W_DEF-1:0]   timeout_bits;
   } baud_cfg_t;

   typedef struct packed {
      logic start;
      logic sample;
      logic bit_end;
      logic false_start;
      logic timeout;
   } baud_strobe_t;

endpackage

// File: rtl/uart_baud_chain.sv
// One timing chain: prescaler with fractional accumulator feeding an
// oversample counter.
//   clk_i, nrst_i : clock, async active-low reset
//   run_i         : chain active; low clears all state next cycle
//   clear_i       : synchronous restart, overrides counting and pulses
//   div_i, frac_i : clocks per sub-tick, integer and fractional part
//   sample_o      : sub-tick at the middle of the bit
//   bit_o         : sub-tick at the end of the bit
module uart_baud_chain #(
   parameter int   OSR    = 16,
   parameter int   DIV_W  = 16,
   parameter int   FRAC_W = 4,
   localparam int  FW     = (FRAC_W > 0) ? FRAC_W : 1
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic             run_i,
   input  logic             clear_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [FW-1:0]    frac_i,
   output logic             sample_o,
   output logic             bit_o
);

   localparam int CNT_W = $clog2(OSR);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OSR/2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

   logic [DIV_W-1:0] pre;
   logic [CNT_W-1:0] sub_cnt;
   logic [FW-1:0]    acc;
   logic             carry;
   logic [DIV_W:0]   period;
   logic [DIV_W:0]   pre_next;
   logic [FW:0]      acc_sum;
   logic             sub_tick;

   // A carry out of the fractional accumulator stretches the next sub-tick
   // by one clock.
   assign period   = {1'b0, div_i} + {{DIV_W{1'b0}}, carry};
   assign pre_next = {1'b0, pre} + {{DIV_W{1'b0}}, 1'b1};
   assign acc_sum  = (FRAC_W > 0) ? ({1'b0, acc} + {1'b0, frac_i}) : '0;

   // >= rather than == so a divisor lowered mid-bit ends the sub-tick at
   // once instead of wrapping the prescaler.
   assign sub_tick = run_i & ~clear_i & (pre_next >= period);
   assign sample_o = sub_tick & (sub_cnt == CNT_MID);
   assign bit_o    = sub_tick & (sub_cnt == CNT_LAST);

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         pre     <= '0;
         sub_cnt <= '0;
         acc     <= '0;
         carry   <= 1'b0;
      end else if (!run_i || clear_i) begin
         pre     <= '0;
         sub_cnt <= '0;
         acc     <= '0;
         carry   <= 1'b0;
      end else if (sub_tick) begin
         pre     <= '0;
         acc     <= acc_sum[FW-1:0];
         carry   <= acc_sum[FW];
         sub_cnt <= (sub_cnt == CNT_LAST) ? '0 : sub_cnt + CNT_ONE;
      end else begin
         pre     <= pre_next[DIV_W-1:0];
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud/timing generator with independent rx and tx chains.
//   clk_i, nrst_i        : clock, async active-low reset
//   en_i                 : global enable, low holds both chains cleared
//   div_i, frac_i        : sub-tick period, integer + frac_i/2^FRAC_W clocks
//   timeout_bits_i       : rx timeout length in bit times, 0 disables
//   rxd_i                : synchronised receive data
//   rx_hunt_i, rx_run_i  : rx FSM accepts a start edge / is not idle
//   tx_run_i             : tx FSM is not idle
//   rx_start_o ... tx_bit_o : single-cycle timing strobes
module uart_baud_gen
   import uart_baud_gen_pkg::*;
#(
   parameter int  OSR    = OSR_DEF,
   parameter int  DIV_W  = DIV_W_DEF,
   parameter int  FRAC_W = FRAC_W_DEF,
   parameter int  TO_W   = TO_W_DEF,
   localparam int FW     = (FRAC_W > 0) ? FRAC_W : 1
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [FW-1:0]    frac_i,
   input  logic [TO_W-1:0]  timeout_bits_i,
   input  logic             rxd_i,
   input  logic             rx_hunt_i,
   input  logic             rx_run_i,
   input  logic             tx_run_i,
   output logic             rx_start_o,
   output logic             rx_sample_o,
   output logic             rx_bit_o,
   output logic             rx_false_start_o,
   output logic             rx_timeout_o,
   output logic             tx_bit_o
);

   logic            gen_en;
   logic            rx_act;
   logic            tx_act;
   logic            rxd_l;
   logic            fs_flag;
   logic [TO_W-1:0] to_cnt;
   logic [TO_W-1:0] to_last;
   baud_strobe_t    rx_s;

   // nrst_i is folded in so that no combinational strobe escapes while
   // reset is held (rxd_l resets high and would otherwise see an edge).
   assign gen_en = nrst_i & en_i & (div_i != '0);
   assign rx_act = gen_en & rx_run_i;
   assign tx_act = gen_en & tx_run_i;

   assign rx_s.start = gen_en & rx_hunt_i & rxd_l & ~rxd_i;

   uart_baud_chain #(.OSR(OSR), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx_chain (
      .clk_i    (clk_i),
      .nrst_i   (nrst_i),
      .run_i    (rx_act),
      .clear_i  (rx_s.start),
      .div_i    (div_i),
      .frac_i   (frac_i),
      .sample_o (rx_s.sample),
      .bit_o    (rx_s.bit_end)
   );

   uart_baud_chain #(.OSR(OSR), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx_chain (
      .clk_i    (clk_i),
      .nrst_i   (nrst_i),
      .run_i    (tx_act),
      .clear_i  (1'b0),
      .div_i    (div_i),
      .frac_i   (frac_i),
      .sample_o (),
      .bit_o    (tx_bit_o)
   );

   assign rx_s.false_start = rx_s.sample & fs_flag & rxd_i;

   assign to_last      = timeout_bits_i - TO_W'(1);
   assign rx_s.timeout = rx_s.bit_end & (timeout_bits_i != '0) & (to_cnt == to_last);

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         rxd_l <= 1'b1;
      end else begin
         rxd_l <= rxd_i;
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         fs_flag <= 1'b0;
      end else if (rx_s.start) begin
         fs_flag <= 1'b1;
      end else if (rx_s.sample) begin
         fs_flag <= 1'b0;
      end
   end

   // Saturating so a timeout length lowered below the running count parks
   // the counter instead of wrapping into a spurious match.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         to_cnt <= '0;
      end else if (!rx_act || rx_s.start || rx_s.timeout) begin
         to_cnt <= '0;
      end else if (rx_s.bit_end && (to_cnt != '1)) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign rx_start_o       = rx_s.start;
   assign rx_sample_o      = rx_s.sample;
   assign rx_bit_o         = rx_s.bit_end;
   assign rx_false_start_o = rx_s.false_start;
   assign rx_timeout_o     = rx_s.timeout;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen at default parameters.
// Cycle n of a scenario is the clock period whose inputs are driven at the
// n-th falling edge after reset release; strobes are sampled 1 time unit
// after that drive. Expected strobes are queued per cycle and compared.
module tb_uart_baud_gen;

   localparam logic [5:0] M_START = 6'b100000;
   localparam logic [5:0] M_SMP   = 6'b010000;
   localparam logic [5:0] M_BIT   = 6'b001000;
   localparam logic [5:0] M_FS    = 6'b000100;
   localparam logic [5:0] M_TO    = 6'b000010;
   localparam logic [5:0] M_TX    = 6'b000001;

   logic        clk_i = 1'b0;
   logic        nrst_i;
   logic        en_i;
   logic [15:0] div_i;
   logic [3:0]  frac_i;
   logic [7:0]  timeout_bits_i;
   logic        rxd_i;
   logic        rx_hunt_i;
   logic        rx_run_i;
   logic        tx_run_i;
   logic        rx_start_o;
   logic        rx_sample_o;
   logic        rx_bit_o;
   logic        rx_false_start_o;
   logic        rx_timeout_o;
   logic        tx_bit_o;

   uart_baud_gen dut (
      .clk_i            (clk_i),
      .nrst_i           (nrst_i),
      .en_i             (en_i),
      .div_i            (div_i),
      .frac_i           (frac_i),
      .timeout_bits_i   (timeout_bits_i),
      .rxd_i            (rxd_i),
      .rx_hunt_i        (rx_hunt_i),
      .rx_run_i         (rx_run_i),
      .tx_run_i         (tx_run_i),
      .rx_start_o       (rx_start_o),
      .rx_sample_o      (rx_sample_o),
      .rx_bit_o         (rx_bit_o),
      .rx_false_start_o (rx_false_start_o),
      .rx_timeout_o     (rx_timeout_o),
      .tx_bit_o         (tx_bit_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int         cyc;
      logic [5:0] mask;
   } exp_t;

   typedef struct {
      logic [15:0] div;
      logic [3:0]  frac;
      int          first;
      int          period;
   } tx_vec_t;

   exp_t    sb[$];
   tx_vec_t tx_tab[5];
   int      checks = 0;
   int      errors = 0;

   task automatic push_exp(input int cyc, input logic [5:0] mask);
      int   i;
      exp_t e;
      i = 0;
      while (i < sb.size() && sb[i].cyc < cyc) i++;
      if (i < sb.size() && sb[i].cyc == cyc) begin
         sb[i].mask = sb[i].mask | mask;
      end else begin
         e.cyc  = cyc;
         e.mask = mask;
         sb.insert(i, e);
      end
   endtask

   task automatic check_cycle(input string tag, input int cyc);
      logic [5:0] exp_m;
      logic [5:0] got;
      exp_m = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_m = sb[0].mask;
         void'(sb.pop_front());
      end
      got = {rx_start_o, rx_sample_o, rx_bit_o, rx_false_start_o, rx_timeout_o, tx_bit_o};
      checks++;
      if (got !== exp_m) begin
         errors++;
         $display("FAIL %s cycle %0d: strobes {start,smp,bit,fs,to,tx} got %b want %b",
                  tag, cyc, got, exp_m);
      end
   endtask

   task automatic end_scn(input string tag);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected strobes left, first at cycle %0d", tag, sb.size(), sb[0].cyc);
      end
      sb.delete();
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      nrst_i         = 1'b0;
      en_i           = 1'b1;
      div_i          = '0;
      frac_i         = '0;
      timeout_bits_i = '0;
      rxd_i          = 1'b1;
      rx_hunt_i      = 1'b0;
      rx_run_i       = 1'b0;
      tx_run_i       = 1'b0;
      repeat (2) @(negedge clk_i);
      nrst_i = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_tab[0] = '{16'd1, 4'd0,  16, 16};
      tx_tab[1] = '{16'd3, 4'd0,  48, 48};
      tx_tab[2] = '{16'd4, 4'd8,  71, 72};
      tx_tab[3] = '{16'd2, 4'd4,  35, 36};
      tx_tab[4] = '{16'd1, 4'd15, 30, 31};

      // Reset held with everything asking for strobes: none may appear.
      nrst_i = 1'b0; en_i = 1'b1; div_i = 16'd1; frac_i = '0; timeout_bits_i = 8'd1;
      rxd_i = 1'b0; rx_hunt_i = 1'b1; rx_run_i = 1'b1; tx_run_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      check_cycle("reset_hold", 0);
      end_scn("reset_hold");

      // Tx timing table: first bit and steady spacing.
      for (int k = 0; k < 5; k++) begin
         int n;
         do_reset();
         div_i  = tx_tab[k].div;
         frac_i = tx_tab[k].frac;
         n = tx_tab[k].first + 2 * tx_tab[k].period + 4;
         for (int b = 0; b < 3; b++) push_exp(tx_tab[k].first + b * tx_tab[k].period, M_TX);
         for (int cyc = 1; cyc <= n; cyc++) begin
            @(negedge clk_i);
            tx_run_i = 1'b1;
            #1;
            check_cycle($sformatf("tx_tab%0d", k), cyc);
         end
         end_scn($sformatf("tx_tab%0d", k));
      end

      // Tx run dropped mid-bit, then restarted from zero.
      do_reset();
      div_i = 16'd1;
      push_exp(16, M_TX); push_exp(32, M_TX); push_exp(76, M_TX);
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(negedge clk_i);
         tx_run_i = (cyc < 40) || (cyc >= 61);
         #1;
         check_cycle("tx_drop", cyc);
      end
      end_scn("tx_drop");

      // Rx start edge, div=3.
      do_reset();
      div_i = 16'd3;
      push_exp(5, M_START);
      for (int b = 0; b < 3; b++) begin
         push_exp(29 + 48 * b, M_SMP);
         push_exp(53 + 48 * b, M_BIT);
      end
      for (int cyc = 1; cyc <= 155; cyc++) begin
         @(negedge clk_i);
         rxd_i     = (cyc < 5);
         rx_hunt_i = (cyc <= 5);
         rx_run_i  = (cyc >= 6);
         #1;
         check_cycle("rx_div3", cyc);
      end
      end_scn("rx_div3");

      // Glitch start: start bit high again at mid-sample, div=2.
      do_reset();
      div_i = 16'd2;
      push_exp(5, M_START);
      push_exp(21, M_SMP | M_FS);
      push_exp(37, M_BIT);
      push_exp(53, M_SMP);
      push_exp(69, M_BIT);
      for (int cyc = 1; cyc <= 72; cyc++) begin
         @(negedge clk_i);
         rxd_i     = !(cyc == 5 || cyc == 6);
         rx_hunt_i = (cyc <= 5);
         rx_run_i  = (cyc >= 6);
         #1;
         check_cycle("false_start", cyc);
      end
      end_scn("false_start");

      // Timeout every 40 bits, no edges.
      do_reset();
      div_i = 16'd1;
      timeout_bits_i = 8'd40;
      for (int k = 1; k <= 90; k++) begin
         if (16 * k - 8 <= 1300) push_exp(16 * k - 8, M_SMP);
         if (16 * k <= 1300) push_exp(16 * k, (k % 40 == 0) ? (M_BIT | M_TO) : M_BIT);
      end
      for (int cyc = 1; cyc <= 1300; cyc++) begin
         @(negedge clk_i);
         rx_run_i = 1'b1;
         #1;
         check_cycle("timeout", cyc);
      end
      end_scn("timeout");

      // Start edge after bit 30 restarts the timeout count.
      do_reset();
      div_i = 16'd1;
      timeout_bits_i = 8'd40;
      for (int k = 1; k <= 30; k++) begin
         push_exp(16 * k - 8, M_SMP);
         push_exp(16 * k, M_BIT);
      end
      push_exp(483, M_START);
      for (int j = 1; j <= 40; j++) begin
         push_exp(483 + 16 * j - 8, M_SMP);
         push_exp(483 + 16 * j, (j == 40) ? (M_BIT | M_TO) : M_BIT);
      end
      for (int cyc = 1; cyc <= 1130; cyc++) begin
         @(negedge clk_i);
         rx_run_i  = 1'b1;
         rx_hunt_i = (cyc == 483);
         rxd_i     = (cyc < 483);
         #1;
         check_cycle("timeout_restart", cyc);
      end
      end_scn("timeout_restart");

      // Halted by div=0, then by en=0: no strobes at all.
      for (int h = 0; h < 2; h++) begin
         do_reset();
         div_i          = (h == 0) ? 16'd0 : 16'd3;
         en_i           = (h == 0);
         timeout_bits_i = 8'd1;
         for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk_i);
            rx_run_i  = 1'b1;
            tx_run_i  = 1'b1;
            rx_hunt_i = 1'b1;
            rxd_i     = cyc[0];
            #1;
            check_cycle((h == 0) ? "halt_div0" : "halt_en0", cyc);
         end
         end_scn((h == 0) ? "halt_div0" : "halt_en0");
      end

      // Reset pulse mid-operation with an rx edge presented during reset.
      do_reset();
      div_i = 16'd1;
      push_exp(16, M_TX);
      push_exp(49, M_TX);
      for (int cyc = 1; cyc <= 55; cyc++) begin
         @(negedge clk_i);
         tx_run_i  = 1'b1;
         rx_hunt_i = 1'b1;
         nrst_i    = !(cyc == 32 || cyc == 33);
         rxd_i     = nrst_i;
         #1;
         check_cycle("reset_mid", cyc);
      end
      end_scn("reset_mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
